// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard with control-flow hold for a simple in-order pipeline.
// Define HAZARD_FORWARD_EN to stall only on a load-use in the cycle right after the load.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned REG_W    = 3,
  parameter int unsigned WB_LAT   = 3,
  parameter int unsigned BR_LAT   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wren,
  input  logic             id_is_load,
  input  logic             id_is_ctrl,
  input  logic             ex_br_resolved,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             nop,
  output logic             IF_ID_Flush
);

  typedef enum logic [0:0] {StRun, StCtrl} state_e;

  state_e              state_q;
  logic [3:0]          bcnt_q;
  logic [3:0]          cnt_q [NUM_REGS];
  logic [3:0]          cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] ld_q, ld_d;

  logic [NUM_REGS-1:0] rs1_sel, rs2_sel, rd_sel, hit_vec;
  logic                raw, issue, ctrl;

  // Decode by comparison so out-of-range specifiers select no entry.
  always_comb begin
    rs1_sel = '0;
    rs2_sel = '0;
    rd_sel  = '0;
    hit_vec = '0;
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      rs1_sel[r] = (id_rs1 == REG_W'(r));
      rs2_sel[r] = (id_rs2 == REG_W'(r));
      rd_sel[r]  = (id_rd == REG_W'(r));
`ifdef HAZARD_FORWARD_EN
      hit_vec[r] = ld_q[r] & (cnt_q[r] == 4'(WB_LAT));
`else
      hit_vec[r] = (cnt_q[r] != 4'd0);
`endif
    end
  end

  always_comb begin
    raw = id_valid & (state_q == StRun) &
          ((id_rs1_used & |(rs1_sel & hit_vec)) | (id_rs2_used & |(rs2_sel & hit_vec)));
    issue       = id_valid & ~raw & (state_q == StRun);
    ctrl        = (state_q == StCtrl) | (issue & id_is_ctrl);
    nop         = raw;
    IF_ID_Write = ~raw;
    PCWrite     = ~(raw | ctrl);
    IF_ID_Flush = ctrl & ~raw;
  end

  // A new write overrides the decrement of its own entry.
  always_comb begin
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      cnt_d[r] = cnt_q[r];
      ld_d[r]  = ld_q[r];
      if (issue & id_wren & rd_sel[r]) begin
        cnt_d[r] = 4'(WB_LAT);
        ld_d[r]  = id_is_load;
      end else if (cnt_q[r] != 4'd0) begin
        cnt_d[r] = cnt_q[r] - 4'd1;
        if (cnt_q[r] == 4'd1) ld_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(NUM_REGS); r++) cnt_q[r] <= 4'd0;
      ld_q <= '0;
    end else begin
      for (int r = 0; r < int'(NUM_REGS); r++) cnt_q[r] <= cnt_d[r];
      ld_q <= ld_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      bcnt_q  <= 4'd0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (issue & id_is_ctrl) begin
            state_q <= StCtrl;
            bcnt_q  <= 4'(BR_LAT);
          end
        end
        StCtrl: begin
          bcnt_q <= bcnt_q - 4'd1;
          if (ex_br_resolved || bcnt_q == 4'd1) state_q <= StRun;
        end
        default: state_q <= StRun;
      endcase
    end
  end

endmodule
